// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : argmax_stream
// Description : Streaming argmax engine. Latches one packed vector of
//               NUM_INPUT scores, scans it LANES elements per cycle and
//               returns the index and value of the largest element. On ties
//               the lowest index wins. Signed or unsigned comparison.
// Ports       : clk      - clock, all state on rising edge
//               rst      - asynchronous reset, active-high
//               i_data   - packed vector, element k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//               i_valid  - input vector valid
//               i_ready  - engine can accept a vector this cycle (out)
//               o_index  - index of the maximum element
//               o_max    - value of the maximum element
//               o_valid  - result valid, held until o_ready
//               o_ready  - consumer accepts the result (in)
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_stream #(
    parameter int  NUM_INPUT   = 10,
    parameter int  INPUT_WIDTH = 16,
    parameter int  LANES       = 1,
    parameter int  SIGNED      = 0,
    localparam int IDX_W       = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
    input  logic                             i_valid,
    output logic                             i_ready,
    output logic [IDX_W-1:0]                 o_index,
    output logic [INPUT_WIDTH-1:0]           o_max,
    output logic                             o_valid,
    input  logic                             o_ready
);

    // Pointer must reach NUM_INPUT+LANES without wrapping.
    localparam int c_PTR_W = $clog2(NUM_INPUT + LANES + 1);
    // Element table is padded to a power of two so the pointer indexes it exactly.
    localparam int c_SLOTS = 1 << c_PTR_W;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_nxt;
    logic [NUM_INPUT*INPUT_WIDTH-1:0] r_buf;
    logic [c_PTR_W-1:0]             r_ptr;
    logic [INPUT_WIDTH-1:0]         r_run_max;
    logic [IDX_W-1:0]               r_run_idx;
    logic [INPUT_WIDTH-1:0]         r_max;
    logic [IDX_W-1:0]               r_index;
    logic                           r_valid;

    logic [INPUT_WIDTH-1:0]         w_elem [c_SLOTS];
    logic [INPUT_WIDTH-1:0]         w_scan_max;
    logic [IDX_W-1:0]               w_scan_idx;
    logic [c_PTR_W-1:0]             w_lane_ptr;
    logic                           w_last;
    logic                           w_ready;
    logic                           w_accept;

    function automatic logic f_gt(input logic [INPUT_WIDTH-1:0] a,
                                  input logic [INPUT_WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Padding slots read as zero; they are never selected because the lane
    // loop masks indices at or beyond NUM_INPUT.
    for (genvar g = 0; g < c_SLOTS; g++) begin : g_elem
        if (g < NUM_INPUT) begin : g_real
            assign w_elem[g] = r_buf[g*INPUT_WIDTH +: INPUT_WIDTH];
        end else begin : g_pad
            assign w_elem[g] = '0;
        end
    end

    // Lanes are folded in ascending index order with a strict compare, so the
    // lowest index survives a tie both inside a group and across cycles.
    always_comb begin
        w_scan_max = r_run_max;
        w_scan_idx = r_run_idx;
        w_lane_ptr = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_ptr = r_ptr + c_PTR_W'(l);
            if ((w_lane_ptr < c_PTR_W'(NUM_INPUT)) && f_gt(w_elem[w_lane_ptr], w_scan_max)) begin
                w_scan_max = w_elem[w_lane_ptr];
                w_scan_idx = IDX_W'(w_lane_ptr);
            end
        end
    end

    // The current group covers the final element.
    assign w_last   = (r_ptr + c_PTR_W'(LANES)) >= c_PTR_W'(NUM_INPUT);

    // Combinational from o_ready so a finished result can hand over to the
    // next vector on the same edge.
    assign w_ready  = !rst && ((r_state == c_IDLE) || ((r_state == c_DONE) && o_ready));
    assign w_accept = i_valid && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (NUM_INPUT > 1) ? c_SCAN : c_DONE;
                end
            end
            c_SCAN: begin
                if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (NUM_INPUT > 1) ? c_SCAN : c_DONE;
                end else if (o_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_buf     <= '0;
            r_ptr     <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_max     <= '0;
            r_index   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_buf     <= i_data;
                r_run_max <= i_data[INPUT_WIDTH-1:0];
                r_run_idx <= '0;
                r_ptr     <= c_PTR_W'(1);
                if (NUM_INPUT == 1) begin
                    // A single element is its own maximum: result is ready at once.
                    r_max   <= i_data[INPUT_WIDTH-1:0];
                    r_index <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (r_state == c_SCAN) begin
                r_run_max <= w_scan_max;
                r_run_idx <= w_scan_idx;
                r_ptr     <= r_ptr + c_PTR_W'(LANES);
                if (w_last) begin
                    r_max   <= w_scan_max;
                    r_index <= w_scan_idx;
                    r_valid <= 1'b1;
                end
            end else if ((r_state == c_DONE) && o_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign i_ready = w_ready;
    assign o_index = r_index;
    assign o_max   = r_max;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_stream
// Description : Self-checking bench for argmax_stream. Four instances cover
//               unsigned L=1, signed L=1, unsigned L=4 and N=1. Results are
//               checked against a value-first argmax model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [159:0] din  [4];
    logic         vin  [4];
    logic         ordy [4];
    logic         irdy [4];
    logic         ovld [4];
    logic [3:0]   oidx [3];
    logic         idx3;
    logic [15:0]  omax [4];

    int n_cmp = 0;
    int n_err = 0;

    int c_n [4] = '{10, 10, 10, 1};
    int c_l [4] = '{1, 1, 4, 1};
    bit c_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(1), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .i_data(din[0]), .i_valid(vin[0]), .i_ready(irdy[0]),
        .o_index(oidx[0]), .o_max(omax[0]), .o_valid(ovld[0]), .o_ready(ordy[0]));
    argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(1), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .i_data(din[1]), .i_valid(vin[1]), .i_ready(irdy[1]),
        .o_index(oidx[1]), .o_max(omax[1]), .o_valid(ovld[1]), .o_ready(ordy[1]));
    argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(4), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .i_data(din[2]), .i_valid(vin[2]), .i_ready(irdy[2]),
        .o_index(oidx[2]), .o_max(omax[2]), .o_valid(ovld[2]), .o_ready(ordy[2]));
    argmax_stream #(.NUM_INPUT(1), .INPUT_WIDTH(16), .LANES(1), .SIGNED(0)) u3 (
        .clk(clk), .rst(rst), .i_data(din[3][15:0]), .i_valid(vin[3]), .i_ready(irdy[3]),
        .o_index(idx3), .o_max(omax[3]), .o_valid(ovld[3]), .o_ready(ordy[3]));

    function automatic int get_idx(input int u);
        case (u)
            0:       return int'(oidx[0]);
            1:       return int'(oidx[1]);
            2:       return int'(oidx[2]);
            default: return int'(idx3);
        endcase
    endfunction

    // Model: find the largest value first, then the first position holding it.
    function automatic void ref_model(input logic [159:0] v, input int u,
                                      output int e_idx, output logic [15:0] e_max);
        logic [15:0] e;
        e_max = v[15:0];
        for (int k = 1; k < c_n[u]; k++) begin
            e = v[k*16 +: 16];
            if (c_s[u] ? ($signed(e) > $signed(e_max)) : (e > e_max)) e_max = e;
        end
        e_idx = -1;
        for (int k = c_n[u] - 1; k >= 0; k--) begin
            if (v[k*16 +: 16] == e_max) e_idx = k;
        end
    endfunction

    function automatic int f_lat(input int u);
        if (c_n[u] == 1) return 0;
        return (c_n[u] - 1 + c_l[u] - 1) / c_l[u];
    endfunction

    // One full transaction: accept, latency, optional stall in DONE, release.
    task automatic do_vector(input int u, input logic [159:0] v, input int stall, input string nm);
        int          e_idx;
        logic [15:0] e_max;
        int          lat;
        int          w;
        ref_model(v, u, e_idx, e_max);
        lat = f_lat(u);
        @(negedge clk);
        din[u]  = v;
        vin[u]  = 1'b1;
        ordy[u] = (stall == 0);
        #1;
        w = 0;
        while (irdy[u] !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (irdy[u] !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_timeout: i_ready=%b required 1", nm, irdy[u]);
            vin[u] = 1'b0;
            return;
        end
        @(negedge clk);
        vin[u] = 1'b0;
        din[u] = {5{$urandom()}};
        for (int c = 0; c < lat; c++) begin
            n_cmp++;
            if (ovld[u] !== 1'b0) begin
                n_err++;
                $display("FAIL %s early_valid u%0d cycle %0d: o_valid=%b required 0", nm, u, c, ovld[u]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ovld[u] !== 1'b1) begin
            n_err++;
            $display("FAIL %s latency u%0d: o_valid=%b required 1 at cycle %0d", nm, u, ovld[u], lat);
        end
        n_cmp++;
        if (get_idx(u) != e_idx) begin
            n_err++;
            $display("FAIL %s index u%0d: got %0d required %0d", nm, u, get_idx(u), e_idx);
        end
        n_cmp++;
        if (omax[u] !== e_max) begin
            n_err++;
            $display("FAIL %s max u%0d: got %h required %h", nm, u, omax[u], e_max);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++;
            if (ovld[u] !== 1'b1 || get_idx(u) != e_idx || omax[u] !== e_max || irdy[u] !== 1'b0) begin
                n_err++;
                $display("FAIL %s hold u%0d: valid=%b idx=%0d max=%h i_ready=%b required 1/%0d/%h/0",
                         nm, u, ovld[u], get_idx(u), omax[u], irdy[u], e_idx, e_max);
            end
        end
        ordy[u] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ovld[u] !== 1'b0) begin
            n_err++;
            $display("FAIL %s valid_drop u%0d: o_valid=%b required 0", nm, u, ovld[u]);
        end
    endtask

    task automatic test_reset();
        vin[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            n_cmp++;
            if (irdy[u] !== 1'b0 || ovld[u] !== 1'b0 || omax[u] !== 16'h0 || get_idx(u) != 0) begin
                n_err++;
                $display("FAIL reset_state u%0d: i_ready=%b valid=%b max=%h idx=%0d required 0/0/0/0",
                         u, irdy[u], ovld[u], omax[u], get_idx(u));
            end
        end
        vin[0] = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (irdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: i_ready=%b required 1", irdy[0]);
        end
    endtask

    task automatic test_tie();
        logic [15:0]  el [10] = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd0, 16'd1, 16'd4, 16'd5, 16'd6, 16'd7};
        logic [159:0] v;
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = el[k];
        do_vector(0, v, 0, "tie_lowest");
    endtask

    task automatic test_signed();
        logic [159:0] v = '0;
        v[15:0]  = 16'hFFFF;
        v[31:16] = 16'h8000;
        v[47:32] = 16'h0005;
        do_vector(1, v, 0, "signed");
        do_vector(0, v, 0, "unsigned_same");
    endtask

    task automatic test_lanes();
        logic [159:0] v;
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'h0100;
        v[159:144] = 16'h7000;
        do_vector(2, v, 0, "lanes4_last");
    endtask

    task automatic test_back_to_back();
        logic [159:0] a = {5{$urandom()}};
        logic [159:0] b = {5{$urandom()}};
        int           ia, ib;
        logic [15:0]  ma, mb;
        int           lat = f_lat(0);
        ref_model(a, 0, ia, ma);
        ref_model(b, 0, ib, mb);
        @(negedge clk);
        din[0] = a; vin[0] = 1'b1; ordy[0] = 1'b0;
        #1;
        n_cmp++;
        if (irdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle_ready: i_ready=%b required 1", irdy[0]);
        end
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (lat) @(negedge clk);
        n_cmp++;
        if (ovld[0] !== 1'b1 || get_idx(0) != ia || omax[0] !== ma) begin
            n_err++;
            $display("FAIL b2b_first: valid=%b idx=%0d max=%h required 1/%0d/%h", ovld[0], get_idx(0), omax[0], ia, ma);
        end
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (ovld[0] !== 1'b1 || get_idx(0) != ia || omax[0] !== ma || irdy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_stall: valid=%b idx=%0d max=%h i_ready=%b required 1/%0d/%h/0",
                         ovld[0], get_idx(0), omax[0], irdy[0], ia, ma);
            end
        end
        ordy[0] = 1'b1; din[0] = b; vin[0] = 1'b1;
        #1;
        n_cmp++;
        if (irdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_comb_ready: i_ready=%b required 1", irdy[0]);
        end
        @(negedge clk);
        vin[0] = 1'b0;
        n_cmp++;
        if (ovld[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drop: o_valid=%b required 0", ovld[0]);
        end
        repeat (lat) @(negedge clk);
        n_cmp++;
        if (ovld[0] !== 1'b1 || get_idx(0) != ib || omax[0] !== mb) begin
            n_err++;
            $display("FAIL b2b_second: valid=%b idx=%0d max=%h required 1/%0d/%h", ovld[0], get_idx(0), omax[0], ib, mb);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [159:0] v = {5{$urandom()}};
        @(negedge clk);
        din[0] = v; vin[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ovld[0] !== 1'b0 || get_idx(0) != 0 || omax[0] !== 16'h0 || irdy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_scan: valid=%b idx=%0d max=%h i_ready=%b required 0/0/0/0",
                     ovld[0], get_idx(0), omax[0], irdy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        do_vector(0, {5{$urandom()}}, 0, "after_reset");
        // Abort while holding a result in DONE.
        @(negedge clk);
        din[0] = {5{$urandom()}}; vin[0] = 1'b1; ordy[0] = 1'b0;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (f_lat(0) + 1) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ovld[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: o_valid=%b required 0", ovld[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        ordy[0] = 1'b1;
    endtask

    task automatic test_single();
        logic [159:0] v = {5{$urandom()}};
        v[15:0] = 16'h0042;
        do_vector(3, v, 0, "single");
        do_vector(3, {5{$urandom()}}, 2, "single_stall");
    endtask

    task automatic test_random();
        logic [15:0]  pool [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [159:0] v;
        int           u;
        for (int it = 0; it < 24; it++) begin
            u = $urandom_range(0, 3);
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 1) == 1) v[k*16 +: 16] = pool[$urandom_range(0, 4)];
                else                           v[k*16 +: 16] = 16'($urandom());
            end
            do_vector(u, v, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            din[u]  = '0;
            vin[u]  = 1'b0;
            ordy[u] = 1'b0;
        end
        test_reset();
        test_tie();
        test_signed();
        test_lanes();
        test_back_to_back();
        test_reset_mid();
        test_single();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
